// File: rtl/sd_spi_responder.sv
// sd_spi_responder
// SD-card SPI-mode responder. It answers the host initialization sequence
// (CMD0, CMD8, CMD55, ACMD41) with R1/R7 responses so an SD init host can be
// exercised without a physical card. sd_clk/sd_cs/sd_mosi are oversampled on
// clk_ref through 2-flop synchronizers.
//
// Parameters:
//   IDLE_POLLS - ACMD41 commands answered 0x01 before the first 0x00 (0..255)
//   NCR_BYTES  - 0xFF bytes between command end bit and response (1..8)
//   VOLT_ACC   - voltage-accepted field returned in R7 bits [11:8]
// Ports:
//   clk_ref    in  system clock
//   rst_n      in  asynchronous active-low reset
//   sd_clk     in  SPI clock from host
//   sd_cs      in  chip select, active low
//   sd_mosi    in  host-to-card data
//   sd_miso    out card-to-host data (idle 1)
//   card_ready out high once ACMD41 returned 0x00, cleared by CMD0
//   cmd_valid  out one-cycle pulse per accepted command frame
//   cmd_idx    out index of the last accepted command
// Build option:
//   SD_RSP_CRC_CHK_EN - when defined, CRC7 of each frame is checked and a
//                       mismatch is answered with R1 = 0x08 | idle bit.
module sd_spi_responder #(
    parameter int unsigned IDLE_POLLS = 2,
    parameter int unsigned NCR_BYTES  = 1,
    parameter logic [3:0]  VOLT_ACC   = 4'b0001
) (
    input  logic       clk_ref,
    input  logic       rst_n,
    input  logic       sd_clk,
    input  logic       sd_cs,
    input  logic       sd_mosi,
    output logic       sd_miso,
    output logic       card_ready,
    output logic       cmd_valid,
    output logic [5:0] cmd_idx
);

    localparam logic [7:0] LP_IDLE_POLLS = 8'(IDLE_POLLS);
    localparam logic [6:0] LP_NCR_BITS   = 7'(NCR_BYTES * 8);

    typedef enum logic [1:0] {CARD_NOSPI, CARD_IDLE, CARD_READY} card_t;
    typedef enum logic [1:0] {PH_HUNT, PH_RX, PH_NCR, PH_TX} phase_t;

    logic [1:0]  r_clk_sync;
    logic [1:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;
    logic        r_clk_prev;
    card_t       r_card;
    phase_t      r_phase;
    logic [5:0]  r_bitcnt;
    logic [6:0]  r_byte;      // last 7 received bits
    logic [5:0]  r_idx_cap;   // frame bits [45:40]
    logic [7:0]  r_echo;      // frame bits [15:8]
    logic        r_hunt_zero; // previous hunted bit was the 0 start bit
    logic [6:0]  r_ncr_cnt;
    logic [39:0] r_tx_data;
    logic [5:0]  r_tx_left;
    logic        r_app_flag;
    logic [7:0]  r_poll_cnt;
    logic        r_card_ready;
    logic        r_cmd_valid;
    logic [5:0]  r_cmd_idx;
    logic        r_miso;

    logic        w_rise;
    logic        w_fall;
    logic        w_mosi;
    logic        w_cs_high;
    logic        w_crc_ok;
    logic        w_idle_bit;
    logic [7:0]  w_r1;
    logic        w_long;
    logic        w_respond;
    card_t       w_card_nxt;
    logic        w_app_nxt;
    logic [7:0]  w_poll_nxt;
    logic        w_ready_nxt;
    logic [39:0] w_rsp_data;
    logic [5:0]  w_rsp_len;

    assign w_rise    = r_clk_sync[1] & ~r_clk_prev;
    assign w_fall    = ~r_clk_sync[1] & r_clk_prev;
    assign w_mosi    = r_mosi_sync[1];
    assign w_cs_high = r_cs_sync[1];

`ifdef SD_RSP_CRC_CHK_EN
    logic [6:0] r_crc;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // At the end bit r_byte holds frame bits [7:1], the transmitted CRC.
    assign w_crc_ok = (r_crc == r_byte);
`else
    assign w_crc_ok = 1'b1;
`endif

    // Two-flop synchronizers for the SPI pins plus sd_clk edge history.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b11;
            r_clk_prev  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], sd_clk};
            r_cs_sync   <= {r_cs_sync[0], sd_cs};
            r_mosi_sync <= {r_mosi_sync[0], sd_mosi};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // Command decode: response and next protocol state for a completed frame.
    always_comb begin
        w_idle_bit  = (r_card == CARD_IDLE);
        w_r1        = 8'h00;
        w_long      = 1'b0;
        w_respond   = 1'b1;
        w_card_nxt  = r_card;
        w_app_nxt   = (r_idx_cap == 6'd55);
        w_poll_nxt  = r_poll_cnt;
        w_ready_nxt = r_card_ready;
        if (!w_crc_ok) begin
            w_app_nxt = r_app_flag;
            if (r_card == CARD_NOSPI) begin
                w_respond = 1'b0;
            end else begin
                w_r1 = 8'h08 | {7'h00, w_idle_bit};
            end
        end else if (r_idx_cap == 6'd0) begin
            w_r1        = 8'h01;
            w_card_nxt  = CARD_IDLE;
            w_poll_nxt  = 8'h00;
            w_ready_nxt = 1'b0;
        end else if (r_card == CARD_NOSPI) begin
            w_respond = 1'b0;
        end else if ((r_idx_cap == 6'd8) && (r_card == CARD_IDLE)) begin
            w_long = 1'b1;
        end else if (r_idx_cap == 6'd55) begin
            w_r1 = {7'h00, w_idle_bit};
        end else if ((r_idx_cap == 6'd41) && r_app_flag) begin
            if (r_card == CARD_READY) begin
                w_r1 = 8'h00;
            end else if (r_poll_cnt < LP_IDLE_POLLS) begin
                w_r1       = 8'h01;
                w_poll_nxt = (r_poll_cnt != 8'hFF) ? (r_poll_cnt + 8'd1) : r_poll_cnt;
            end else begin
                w_r1        = 8'h00;
                w_card_nxt  = CARD_READY;
                w_ready_nxt = 1'b1;
            end
        end else begin
            w_r1 = 8'h04 | {7'h00, w_idle_bit};
        end
        if (w_long) begin
            w_rsp_data = {8'h01, 8'h00, 8'h00, 4'h0, VOLT_ACC, r_echo};
            w_rsp_len  = 6'd40;
        end else begin
            w_rsp_data = {w_r1, 32'h0000_0000};
            w_rsp_len  = 6'd8;
        end
    end

    // Frame receive, protocol state and response shifting.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_card       <= CARD_NOSPI;
            r_phase      <= PH_HUNT;
            r_bitcnt     <= 6'd0;
            r_byte       <= 7'd0;
            r_idx_cap    <= 6'd0;
            r_echo       <= 8'd0;
            r_hunt_zero  <= 1'b0;
            r_ncr_cnt    <= 7'd0;
            r_tx_data    <= 40'd0;
            r_tx_left    <= 6'd0;
            r_app_flag   <= 1'b0;
            r_poll_cnt   <= 8'd0;
            r_card_ready <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_idx    <= 6'd0;
            r_miso       <= 1'b1;
`ifdef SD_RSP_CRC_CHK_EN
            r_crc        <= 7'd0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_cs_high) begin
                // Deselect aborts any transfer; card state is kept.
                r_phase     <= PH_HUNT;
                r_bitcnt    <= 6'd0;
                r_hunt_zero <= 1'b0;
                r_ncr_cnt   <= 7'd0;
                r_miso      <= 1'b1;
            end else begin
                case (r_phase)
                    PH_HUNT: begin
                        r_miso <= 1'b1;
                        if (w_rise) begin
                            if (r_hunt_zero && w_mosi) begin
                                r_phase     <= PH_RX;
                                r_bitcnt    <= 6'd2;
                                r_byte      <= 7'b000_0001;
                                r_hunt_zero <= 1'b0;
`ifdef SD_RSP_CRC_CHK_EN
                                r_crc       <= 7'h09; // CRC7 after bits 0,1
`endif
                            end else begin
                                r_hunt_zero <= ~w_mosi;
                            end
                        end
                    end
                    PH_RX: begin
                        if (w_rise) begin
                            r_byte <= {r_byte[5:0], w_mosi};
`ifdef SD_RSP_CRC_CHK_EN
                            if (r_bitcnt <= 6'd39) begin
                                r_crc <= crc7_step(r_crc, w_mosi);
                            end
`endif
                            if (r_bitcnt == 6'd7) begin
                                r_idx_cap <= {r_byte[4:0], w_mosi};
                            end
                            if (r_bitcnt == 6'd39) begin
                                r_echo <= {r_byte, w_mosi};
                            end
                            if (r_bitcnt == 6'd47) begin
                                r_bitcnt <= 6'd0;
                                if (w_mosi) begin
                                    r_cmd_valid  <= 1'b1;
                                    r_cmd_idx    <= r_idx_cap;
                                    r_card       <= w_card_nxt;
                                    r_app_flag   <= w_app_nxt;
                                    r_poll_cnt   <= w_poll_nxt;
                                    r_card_ready <= w_ready_nxt;
                                    if (w_respond) begin
                                        r_phase   <= PH_NCR;
                                        r_ncr_cnt <= 7'd0;
                                        r_tx_data <= w_rsp_data;
                                        r_tx_left <= w_rsp_len;
                                    end else begin
                                        r_phase <= PH_HUNT;
                                    end
                                end else begin
                                    r_phase <= PH_HUNT;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                            end
                        end
                    end
                    PH_NCR: begin
                        if (w_fall) begin
                            if (r_ncr_cnt == LP_NCR_BITS) begin
                                r_phase   <= PH_TX;
                                r_miso    <= r_tx_data[39];
                                r_tx_data <= {r_tx_data[38:0], 1'b0};
                                r_tx_left <= r_tx_left - 6'd1;
                            end else begin
                                r_ncr_cnt <= r_ncr_cnt + 7'd1;
                                r_miso    <= 1'b1;
                            end
                        end
                    end
                    PH_TX: begin
                        if (w_fall) begin
                            if (r_tx_left == 6'd0) begin
                                r_phase     <= PH_HUNT;
                                r_miso      <= 1'b1;
                                r_hunt_zero <= 1'b0;
                            end else begin
                                r_miso    <= r_tx_data[39];
                                r_tx_data <= {r_tx_data[38:0], 1'b0};
                                r_tx_left <= r_tx_left - 6'd1;
                            end
                        end
                    end
                    default: begin
                        r_phase <= PH_HUNT;
                    end
                endcase
            end
        end
    end

    assign sd_miso    = r_miso;
    assign card_ready = r_card_ready;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_idx    = r_cmd_idx;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed testbench for sd_spi_responder acting as an SPI host.
module tb_sd_spi_responder;

    localparam int HALF = 6; // clk_ref cycles per sd_clk phase

    localparam logic [47:0] CMD0     = 48'h40_00_00_00_00_95;
    localparam logic [47:0] CMD8     = 48'h48_00_00_01_AA_87;
    localparam logic [47:0] CMD55    = 48'h77_00_00_00_00_65;
    localparam logic [47:0] CMD55_NE = 48'h77_00_00_00_00_64; // end bit 0
    localparam logic [47:0] ACMD41   = 48'h69_40_00_00_00_77;

    logic       clk_ref = 1'b0;
    logic       rst_n;
    logic       sd_clk;
    logic       sd_cs;
    logic       sd_mosi;
    logic       sd_miso;
    logic       card_ready;
    logic       cmd_valid;
    logic [5:0] cmd_idx;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    logic [5:0] last_idx = 6'd0;
    logic [7:0] rb [0:7];
    logic [47:0] cap48;
    int         v_before;

    sd_spi_responder dut (
        .clk_ref    (clk_ref),
        .rst_n      (rst_n),
        .sd_clk     (sd_clk),
        .sd_cs      (sd_cs),
        .sd_mosi    (sd_mosi),
        .sd_miso    (sd_miso),
        .card_ready (card_ready),
        .cmd_valid  (cmd_valid),
        .cmd_idx    (cmd_idx)
    );

    always #5 clk_ref = ~clk_ref;

    // Count cmd_valid pulses and remember the index seen with each.
    always @(negedge clk_ref) begin
        if (cmd_valid === 1'b1) begin
            n_valid  = n_valid + 1;
            last_idx = cmd_idx;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_ref);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sd_mosi = tx[i];
            wait_clk(HALF);
            sd_clk = 1'b1;
            rx[i]  = sd_miso;
            wait_clk(HALF);
            sd_clk = 1'b0;
        end
    endtask

    task automatic spi_bits(input logic [47:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            sd_mosi = f[47-i];
            wait_clk(HALF);
            sd_clk = 1'b1;
            wait_clk(HALF);
            sd_clk = 1'b0;
        end
        sd_mosi = 1'b1;
    endtask

    task automatic cmd_rsp(input logic [47:0] f, input int nrd);
        spi_bits(f, 48);
        for (int i = 0; i < nrd; i++) begin
            spi_byte(8'hFF, rb[i]);
        end
    endtask

    // Expect one NCR byte, one R1 byte, then idle ones.
    task automatic expect_r1(input string tag, input logic [47:0] f, input logic [7:0] r1);
        cmd_rsp(f, 3);
        check_eq(tag, {rb[0], rb[1], rb[2]}, {8'hFF, r1, 8'hFF});
    endtask

    task automatic expect_none(input string tag, input logic [47:0] f);
        cmd_rsp(f, 3);
        check_eq(tag, {rb[0], rb[1], rb[2]}, 24'hFF_FFFF);
    endtask

    initial begin
        rst_n   = 1'b0;
        sd_clk  = 1'b0;
        sd_cs   = 1'b1;
        sd_mosi = 1'b1;
        wait_clk(3);
        check_eq("rst_miso", sd_miso, 1'b1);
        check_eq("rst_ready", card_ready, 1'b0);
        check_eq("rst_valid", cmd_valid, 1'b0);
        check_eq("rst_idx", cmd_idx, 6'd0);
        rst_n = 1'b1;
        wait_clk(4);
        sd_cs = 1'b0;
        wait_clk(4);

        // CMD8 before any CMD0: accepted but never answered.
        cmd_rsp(CMD8, 7);
        check_eq("nospi_cmd8", {rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], rb[6]}, 56'hFF_FFFF_FFFF_FFFF);
        check_eq("nospi_valid", n_valid, 1);
        check_eq("nospi_idx", last_idx, 6'd8);

        expect_r1("cmd0", CMD0, 8'h01);
        check_eq("cmd0_valid", n_valid, 2);
        check_eq("cmd0_idx", last_idx, 6'd0);
        check_eq("cmd0_ready", card_ready, 1'b0);

        cmd_rsp(CMD8, 7);
        check_eq("r7", {rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], rb[6]}, 56'hFF_01_00_00_01_AA_FF);
        cap48 = {rb[1], rb[2], rb[3], rb[4], rb[5], rb[6]};
        check_eq("r7_volt", cap48[19:16], 4'b0001);
        check_eq("cmd8_idx", last_idx, 6'd8);

        expect_r1("acmd41_noapp", ACMD41, 8'h05);

        expect_r1("cmd55_1", CMD55, 8'h01);
        expect_r1("acmd41_1", ACMD41, 8'h01);
        expect_r1("cmd55_2", CMD55, 8'h01);
        expect_r1("acmd41_2", ACMD41, 8'h01);
        check_eq("ready_before", card_ready, 1'b0);
        expect_r1("cmd55_3", CMD55, 8'h01);
        expect_r1("acmd41_3", ACMD41, 8'h00);
        check_eq("ready_after", card_ready, 1'b1);
        check_eq("acmd41_idx", last_idx, 6'd41);

        expect_r1("cmd55_ready", CMD55, 8'h00);
        expect_r1("acmd41_ready", ACMD41, 8'h00);
        expect_r1("cmd8_ready", CMD8, 8'h04);

        // Frame with end bit 0 is dropped silently.
        v_before = n_valid;
        expect_none("endbit0", CMD55_NE);
        check_eq("endbit0_valid", n_valid, v_before);

        // Asynchronous reset in the middle of an NCR phase.
        spi_bits(CMD55, 48);
        spi_bits(48'hFFFF_FFFF_FFFF, 4);
        rst_n = 1'b0;
        #1;
        check_eq("arst_miso", sd_miso, 1'b1);
        check_eq("arst_ready", card_ready, 1'b0);
        check_eq("arst_idx", cmd_idx, 6'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        expect_none("arst_nospi", CMD8);

        expect_r1("cmd0_again", CMD0, 8'h01);

        // CMD55 aborted during its response still leaves app_flag set.
        spi_bits(CMD55, 48);
        spi_byte(8'hFF, rb[0]);
        spi_bits(48'hFFFF_FFFF_FFFF, 3);
        wait_clk(4);
        check_eq("tx_bit_low", sd_miso, 1'b0);
        sd_cs = 1'b1;
        wait_clk(4);
        check_eq("tx_abort_miso", sd_miso, 1'b1);
        sd_cs = 1'b0;
        wait_clk(4);
        expect_r1("acmd41_after_abort", ACMD41, 8'h01);

        // CS raised after 20 bits of CMD55: no response, no valid pulse.
        v_before = n_valid;
        spi_bits(CMD55, 20);
        sd_cs = 1'b1;
        wait_clk(4);
        check_eq("cs_abort_miso", sd_miso, 1'b1);
        check_eq("cs_abort_valid", n_valid, v_before);
        sd_cs = 1'b0;
        wait_clk(4);
        expect_r1("cmd0_after_abort", CMD0, 8'h01);
        check_eq("cmd0_after_abort_idx", last_idx, 6'd0);

`ifdef SD_RSP_CRC_CHK_EN
        // CRC field 0x42 instead of 0x43 (end bit kept at 1).
        expect_r1("crc_bad", 48'h48_00_00_01_AA_85, 8'h09);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
